coin_pulse_classifier: RTL and testbench

Single-slot coin front end for the piggy bank. It watches one debounced coin-sensor line, measures how long each coin keeps the sensor high in clock cycles, and sorts the coin into 10/5/2/1 baht or reject. It then emits a one-cycle strobe on the matching output. Those strobes feed the per-denomination coin counters that drive the UART report, replacing the four separate per-denomination input pins.

---
 rtl/coin_pulse_classifier.sv | 129 ++++++++++++
 tb/tb_coin_pulse_classifier.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_classifier.sv
// coin_pulse_classifier: measures how long a coin holds the debounced sensor
// high and sorts it into 10/5/2/1 baht or reject, emitting a one-cycle strobe.
// Optional build macro: PIGGY_REJECT_TALLY_EN adds a saturating reject tally
// on reject_count. Without it, reject_count is tied to zero.
module coin_pulse_classifier #(
  parameter int CNT_W   = 12,
  parameter int T1_MIN  = 100,
  parameter int T2_MIN  = 200,
  parameter int T5_MIN  = 400,
  parameter int T10_MIN = 800,
  parameter int T_MAX   = 1600,
  parameter int GAP_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_in,
  output logic       coin_10,
  output logic       coin_5,
  output logic       coin_2,
  output logic       coin_1,
  output logic       reject,
  output logic       busy,
  output logic [7:0] reject_count
);

  localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0] T1_C   = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] T2_C   = CNT_W'(T2_MIN);
  localparam logic [CNT_W-1:0] T5_C   = CNT_W'(T5_MIN);
  localparam logic [CNT_W-1:0] T10_C  = CNT_W'(T10_MIN);
  localparam logic [CNT_W-1:0] TMAX_C = CNT_W'(T_MAX);
  localparam logic [GAP_W-1:0] GAP_C  = GAP_W'(GAP_CYC);

  typedef enum logic [1:0] {IDLE, MEASURE, JAM, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap;
  logic               s_q;
  logic               rise;

  // s_q resets high so a line already high at reset release is never a rising edge
  assign rise = sense_in & ~s_q;

  // Pulse-width FSM; strobes and busy are registered and strobes default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gap     <= '0;
      s_q     <= 1'b1;
      coin_10 <= 1'b0;
      coin_5  <= 1'b0;
      coin_2  <= 1'b0;
      coin_1  <= 1'b0;
      reject  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      s_q     <= sense_in;
      coin_10 <= 1'b0;
      coin_5  <= 1'b0;
      coin_2  <= 1'b0;
      coin_1  <= 1'b0;
      reject  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (sense_in) begin
            cnt <= cnt + 1'b1;
            // cnt is about to pass T_MAX: the coin is stuck, flag it once
            if (cnt == TMAX_C) begin
              reject <= 1'b1;
              state  <= JAM;
            end
          end else begin
            if (cnt < T1_C)       reject  <= 1'b1;
            else if (cnt < T2_C)  coin_1  <= 1'b1;
            else if (cnt < T5_C)  coin_2  <= 1'b1;
            else if (cnt < T10_C) coin_5  <= 1'b1;
            else                  coin_10 <= 1'b1;
            gap   <= GAP_C;
            state <= GAP;
          end
        end
        JAM: begin
          if (!sense_in) begin
            gap   <= GAP_C;
            state <= GAP;
          end
        end
        GAP: begin
          // sensor activity is ignored until the lockout expires
          if (gap == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap <= gap - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIGGY_REJECT_TALLY_EN
  logic [7:0] tally;

  // Saturating count of reject strobes, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                          tally <= 8'h00;
    else if (reject && tally != 8'hFF) tally <= tally + 8'h01;
  end

  assign reject_count = tally;
`else
  assign reject_count = 8'h00;
`endif

endmodule

// File: tb/tb_coin_pulse_classifier.sv
// Scoreboard bench for coin_pulse_classifier: stimulus pushes expected
// strobes (kind + cycle) into a queue; a monitor pops and compares them.
module tb_coin_pulse_classifier;

  localparam int K10 = 0, K5 = 1, K2 = 2, K1 = 3, KREJ = 4;

`ifdef PIGGY_REJECT_TALLY_EN
  localparam int TALLY_ON = 1;
`else
  localparam int TALLY_ON = 0;
`endif

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_in;
  logic       coin_10, coin_5, coin_2, coin_1, reject, busy;
  logic [7:0] reject_count;

  logic       sense2;
  logic       c10_2, c5_2, c2_2, c1_2, rej_2, busy_2;
  logic [7:0] rc_2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   bad2   = 0;
  int   rej2_n = 0;
  exp_t q[$];

  coin_pulse_classifier dut (
    .clk(clk), .rst(rst), .sense_in(sense_in),
    .coin_10(coin_10), .coin_5(coin_5), .coin_2(coin_2), .coin_1(coin_1),
    .reject(reject), .busy(busy), .reject_count(reject_count)
  );

  // Small thresholds so the saturating tally can be reached quickly
  coin_pulse_classifier #(
    .CNT_W(8), .T1_MIN(20), .T2_MIN(30), .T5_MIN(40), .T10_MIN(50),
    .T_MAX(60), .GAP_CYC(4)
  ) dut_tally (
    .clk(clk), .rst(rst), .sense_in(sense2),
    .coin_10(c10_2), .coin_5(c5_2), .coin_2(c2_2), .coin_1(c1_2),
    .reject(rej_2), .busy(busy_2), .reject_count(rc_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c10_2 | c5_2 | c2_2 | c1_2) bad2 <= bad2 + 1;
    if (rej_2) rej2_n <= rej2_n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    q.push_back(e);
  endtask

  // Drives a pulse of w high samples; caller is 1 time unit after a rising edge
  task automatic pulse(input int w, input int kind);
    int start;
    start = cyc;
    if (kind >= 0) push(kind, (kind == KREJ && w > 1600) ? start + 1601 : start + w + 1);
    sense_in = 1'b1;
    tick(w);
    sense_in = 1'b0;
  endtask

  function automatic int strobe_kind();
    if (coin_10) return K10;
    if (coin_5)  return K5;
    if (coin_2)  return K2;
    if (coin_1)  return K1;
    return KREJ;
  endfunction

  initial begin
    rst = 1'b1; sense_in = 1'b1; sense2 = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (coin_10 | coin_5 | coin_2 | coin_1 | reject) begin
          exp_t e;
          chk("onehot", $countones({coin_10, coin_5, coin_2, coin_1, reject}), 1);
          if (q.size() == 0) begin
            chk("unexpected_strobe_kind", strobe_kind(), -1);
          end else begin
            e = q.pop_front();
            chk("strobe_kind", strobe_kind(), e.kind);
            chk("strobe_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset with the line already high: outputs idle, and no measurement on release
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {coin_10, coin_5, coin_2, coin_1, reject}, 0);
    chk("rst_reject_count", reject_count, 0);
    rst = 1'b0;
    tick(5);
    chk("high_at_release_busy", busy, 0);
    sense_in = 1'b0;
    tick(3);

    // 150-cycle coin_1, busy timing around gap expiry
    pulse(150, K1);
    chk("busy_during_measure_end", busy, 1);
    tick(1);          // strobe cycle
    tick(500);
    chk("busy_last_gap_cycle", busy, 1);
    tick(1);
    chk("busy_gap_expired", busy, 0);
    tick(50);

    // Threshold sweep
    pulse(99, KREJ);   tick(600);
    pulse(200, K2);    tick(600);
    pulse(799, K5);    tick(600);
    pulse(1600, K10);  tick(600);

    // Jam: one reject while still high, nothing when the line falls
    pulse(2000, KREJ);
    chk("jam_busy_at_fall", busy, 1);
    tick(501);
    chk("jam_busy_gap_last", busy, 1);
    tick(1);
    chk("jam_busy_done", busy, 0);
    chk("reject_count_after_two", reject_count, TALLY_ON ? 2 : 0);
    tick(50);

    // Pulse inside GAP ignored; line still high at gap end ignored
    pulse(150, K1);
    tick(101);        // strobe + 100
    pulse(300, -1);
    tick(700);
    chk("gap_pulse_busy", busy, 0);
    pulse(150, K1);
    tick(401);        // strobe + 400, overlaps gap end
    pulse(300, -1);
    chk("gap_overlap_busy", busy, 0);
    tick(600);

    // Reset mid-measurement aborts the pulse
    sense_in = 1'b1;
    tick(50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy_after_rst", busy, 0);
    tick(849);
    sense_in = 1'b0;
    tick(10);
    chk("abort_busy_after_fall", busy, 0);
    pulse(900, K10);
    tick(600);

    // Tally on the small-threshold instance
    for (int i = 0; i < 260; i++) begin
      sense2 = 1'b1;
      tick(10);
      sense2 = 1'b0;
      tick(12);
      if (i == 99) chk("tally_100", rc_2, TALLY_ON ? 100 : 0);
    end
    chk("tally_260_saturated", rc_2, TALLY_ON ? 255 : 0);
    chk("tally_reject_strobes", rej2_n, 260);
    chk("tally_no_coin_strobes", bad2, 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
